// File: rtl/counter_pkg.sv
// Shared types for the counter block and its tick_prescaler front end.
// Prescaler state enum and the default counter width.
package counter_pkg;

  localparam int COUNTER_WIDTH_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } presc_state_t;

endpackage

// File: rtl/tick_prescaler.sv
// Loadable clock prescaler producing a one-cycle tick every div+1 enabled cycles.
// Optional one-shot mode (oneshot port, DONE state) via TICK_PRESCALER_ONESHOT_EN.
module tick_prescaler
  import counter_pkg::*;
#(
  parameter int          WIDTH     = COUNTER_WIDTH_DEFAULT,
  parameter int unsigned DIV_RESET = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] div_value,
`ifdef TICK_PRESCALER_ONESHOT_EN
  input  logic             oneshot,
`endif
  output logic             tick,
  output logic             busy,
  output logic [WIDTH-1:0] phase
);

  presc_state_t     state, state_d;
  logic [WIDTH-1:0] div_reg, div_d;
  logic [WIDTH-1:0] cnt, cnt_d;
  logic             tick_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      div_reg <= WIDTH'(DIV_RESET);
      cnt     <= '0;
      tick    <= 1'b0;
    end else begin
      state   <= state_d;
      div_reg <= div_d;
      cnt     <= cnt_d;
      tick    <= tick_d;
    end
  end

  always_comb begin
    state_d = state;
    div_d   = div_reg;
    cnt_d   = cnt;
    tick_d  = 1'b0;
    if (load) begin
      div_d   = div_value;
      cnt_d   = '0;
      state_d = en ? RUN : IDLE;
    end else begin
      case (state)
        // Count on the IDLE->RUN edge too, so a pause of K cycles costs K.
        IDLE, RUN: begin
          if (en) begin
            state_d = RUN;
            if (cnt == div_reg) begin
              cnt_d  = '0;
              tick_d = 1'b1;
`ifdef TICK_PRESCALER_ONESHOT_EN
              if (oneshot) state_d = DONE;
`endif
            end else begin
              cnt_d = cnt + 1'b1;
            end
          end else begin
            state_d = IDLE;
          end
        end
`ifdef TICK_PRESCALER_ONESHOT_EN
        DONE: begin
          if (!en) state_d = IDLE;
        end
`endif
        default: state_d = IDLE;
      endcase
    end
  end

  assign busy  = (state == RUN);
  assign phase = cnt;

endmodule

// File: tb/tb_tick_prescaler.sv
// Directed scoreboard bench for tick_prescaler (WIDTH=4, DIV_RESET=2).
// One-shot steps are compiled in when TICK_PRESCALER_ONESHOT_EN is defined.
module tb_tick_prescaler;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic         load;
  logic [W-1:0] div_value;
  logic         oneshot;
  logic         tick;
  logic         busy;
  logic [W-1:0] phase;

  typedef struct {
    logic         tick;
    logic         busy;
    logic [W-1:0] phase;
  } exp_t;

  exp_t q[$];

  int checks = 0;
  int errors = 0;
  int ntick  = 0;
  int n;

  // reference model state: 0 idle, 1 run, 2 done
  int           m_st;
  logic [W-1:0] m_div;
  logic [W-1:0] m_cnt;
  logic         m_tick;

  tick_prescaler #(.WIDTH(W), .DIV_RESET(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .load      (load),
    .div_value (div_value),
`ifdef TICK_PRESCALER_ONESHOT_EN
    .oneshot   (oneshot),
`endif
    .tick      (tick),
    .busy      (busy),
    .phase     (phase)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic model();
    logic os;
`ifdef TICK_PRESCALER_ONESHOT_EN
    os = oneshot;
`else
    os = 1'b0;
`endif
    m_tick = 1'b0;
    if (!rst_n) begin
      m_st = 0; m_div = 4'd2; m_cnt = '0;
    end else if (load) begin
      m_div = div_value; m_cnt = '0;
      m_st = en ? 1 : 0;
    end else if (m_st == 2) begin
      if (!en) m_st = 0;
    end else if (en) begin
      if (m_cnt == m_div) begin
        m_cnt = '0; m_tick = 1'b1;
        m_st = os ? 2 : 1;
      end else begin
        m_cnt = m_cnt + 1'b1; m_st = 1;
      end
    end else begin
      m_st = 0;
    end
  endtask

  task automatic cyc(input logic e, input logic ld,
                     input logic [W-1:0] dv);
    exp_t ex;
    @(negedge clk);
    en = e; load = ld; div_value = dv;
    model();
    q.push_back('{tick: m_tick, busy: (m_st == 1), phase: m_cnt});
    @(posedge clk);
    #1;
    ex = q.pop_front();
    chk("tick",  32'(tick),  32'(ex.tick));
    chk("busy",  32'(busy),  32'(ex.busy));
    chk("phase", 32'(phase), 32'(ex.phase));
    if (tick === 1'b1) ntick++;
  endtask

  task automatic until_tick(input int bound, output int cnt_o);
    cnt_o = 0;
    do begin
      cyc(1'b1, 1'b0, '0);
      cnt_o++;
    end while (tick !== 1'b1 && cnt_o < bound);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; load = 1'b0;
    div_value = '0; oneshot = 1'b0;

    // reset held 3 clocks, then released idle
    repeat (3) cyc(1'b0, 1'b0, '0);
    rst_n = 1'b1;
    cyc(1'b0, 1'b0, '0);
    chk("rst_tick", 32'(tick), 32'd0);
    chk("rst_phase", 32'(phase), 32'd0);
    until_tick(10, n);
    chk("rst_ratio", n, 3);

    // periodic ratio 3
    cyc(1'b1, 1'b1, 4'd3);
    ntick = 0;
    repeat (20) cyc(1'b1, 1'b0, '0);
    chk("periodic_cnt", ntick, 5);

    // pause at phase 2
    cyc(1'b1, 1'b1, 4'd5);
    repeat (2) cyc(1'b1, 1'b0, '0);
    repeat (3) cyc(1'b0, 1'b0, '0);
    chk("pause_phase", 32'(phase), 32'd2);
    chk("pause_busy", 32'(busy), 32'd0);
    until_tick(20, n);
    chk("pause_delay", n, 4);

    // load mid-period
    cyc(1'b1, 1'b1, 4'd7);
    repeat (4) cyc(1'b1, 1'b0, '0);
    chk("mid_phase", 32'(phase), 32'd4);
    cyc(1'b1, 1'b1, 4'd1);
    chk("mid_load_tick", 32'(tick), 32'd0);
    ntick = 0;
    repeat (6) cyc(1'b1, 1'b0, '0);
    chk("mid_ticks", ntick, 3);

    // ratio 0: tick every cycle
    cyc(1'b1, 1'b1, 4'd0);
    ntick = 0;
    repeat (5) cyc(1'b1, 1'b0, '0);
    chk("ratio0", ntick, 5);

    // full-scale ratio wraps after 16 cycles
    cyc(1'b1, 1'b1, 4'd15);
    until_tick(40, n);
    chk("wrap", n, 16);

    // load with en low parks idle
    cyc(1'b0, 1'b1, 4'd3);
    chk("load_idle", 32'(busy), 32'd0);

    // reset mid-period
    cyc(1'b1, 1'b0, '0);
    cyc(1'b1, 1'b0, '0);
    rst_n = 1'b0;
    cyc(1'b1, 1'b0, '0);
    chk("midrst_phase", 32'(phase), 32'd0);
    rst_n = 1'b1;
    cyc(1'b0, 1'b0, '0);

`ifdef TICK_PRESCALER_ONESHOT_EN
    oneshot = 1'b1;
    cyc(1'b1, 1'b1, 4'd2);
    ntick = 0;
    repeat (8) cyc(1'b1, 1'b0, '0);
    chk("os_ticks", ntick, 1);
    chk("os_busy", 32'(busy), 32'd0);
    chk("os_phase", 32'(phase), 32'd0);
    cyc(1'b0, 1'b0, '0);
    until_tick(20, n);
    chk("os_rearm", n, 3);
    oneshot = 1'b0;
    cyc(1'b0, 1'b0, '0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
